bp_table_update_ctrl: RTL and testbench
=======================================

BP_TABLE_UPDATE_CTRL -- requirements
Module: bp_table_update_ctrl

Interface
REQ-001 Parameter IDX_W, default 10: table index width; table depth is 2**IDX_W.
REQ-002 Parameter DATA_W, default 2: table entry width (2-bit saturating state).
REQ-003 Parameter DEPTH, default 4: update FIFO depth (power of two, at least 2).
REQ-004 Parameter INIT_VAL, default 2'b00: entry value written by init/flush sweeps.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 upd_valid  in  1  resolved-branch table update request.
REQ-008 upd_index  in  IDX_W  entry to write.
REQ-009 upd_data  in  DATA_W  new entry value from the predictor FSM.
REQ-010 upd_ready  out  1  update accepted this cycle when upd_valid and upd_ready are both high.
REQ-011 flush_req  in  1  one-cycle pulse; discard queued updates and re-sweep the table.
REQ-012 wr_en  out  1  table write strobe.
REQ-013 wr_index  out  IDX_W  table write address.
REQ-014 wr_data  out  DATA_W  table write data.
REQ-015 rd_index  in  IDX_W  predict-stage lookup index.
REQ-016 fwd_hit  out  1  a queued update matches rd_index.
REQ-017 fwd_data  out  DATA_W  data of the youngest matching queued update.
REQ-018 busy  out  1  sweep in progress; table contents invalid.
REQ-019 err_drop  out  1  sticky flag: an update was offered while upd_ready was low.

Function
REQ-020 States: INIT, RUN, FLUSH; the state register and sweep counter SHALL update on posedge clk.
REQ-021 In INIT and FLUSH, each cycle: wr_en=1, wr_index=sweep counter, wr_data=INIT_VAL, and the counter SHALL increment.
REQ-022 When the counter reaches 2**IDX_W-1, that entry is written and the next state SHALL be RUN, with the counter cleared to 0.
REQ-023 A full sweep SHALL take exactly 2**IDX_W cycles; busy=1 throughout and busy=0 in RUN.
REQ-024 upd_ready SHALL be (count < DEPTH) and not flush_req; there is no push-through when full, even if a pop occurs in the same cycle.
REQ-025 A push SHALL store {upd_index, upd_data} at the FIFO tail; this is allowed in all states.
REQ-026 In RUN with count > 0: wr_en=1 and wr_index/wr_data are driven from the FIFO head, combinationally; the head SHALL pop at the same edge.
REQ-027 In RUN with count = 0: wr_en=0; wr_index and wr_data are don't-care, driven 0.
REQ-028 Latency: an update accepted into an empty FIFO at edge N in RUN SHALL appear on the write port during the cycle after edge N.
REQ-029 A simultaneous push and pop SHALL leave count unchanged, and FIFO order SHALL be preserved.
REQ-030 Sweep writes SHALL have priority; the FIFO SHALL NOT drain while busy=1.
REQ-031 When flush_req=1 in any state: at that edge the FIFO is emptied (count=0), the counter is set to 0, and the state SHALL become FLUSH.
REQ-032 flush_req during a sweep SHALL restart the sweep from index 0.
REQ-033 flush_req and upd_valid in the same cycle: the update SHALL be rejected (upd_ready=0) and err_drop set.
REQ-034 fwd_hit and fwd_data are combinational over valid FIFO entries; on multiple matches, the youngest entry SHALL win.
REQ-035 With no match: fwd_hit=0 and fwd_data=0.
REQ-036 err_drop SHALL set on upd_valid && !upd_ready and clear only on rst.
REQ-037 The pointers and count SHALL wrap modulo DEPTH, with count ranging 0..DEPTH.

Reset
REQ-038 On rst assertion, asynchronously: state=INIT, counter=0, FIFO empty, err_drop=0.
REQ-039 The resulting outputs while rst is held SHALL be: busy=1, wr_en=1, wr_index=0, wr_data=INIT_VAL, upd_ready=1, fwd_hit=0.
REQ-040 rst asserted mid-sweep or mid-drain SHALL discard all queued updates and restart the INIT sweep at index 0 after rst deasserts.

Verification
REQ-041 Release rst and idle -> wr_en=1 for 1024 consecutive cycles with wr_index 0..1023 and wr_data=INIT_VAL; then busy=0 and wr_en=0.
REQ-042 In RUN, push (5,2'b11), (9,2'b10), (5,2'b01) on back-to-back cycles -> writes in order 5/11, 9/10, 5/01; with rd_index=5 while all three are queued, fwd_hit=1 and fwd_data=2'b01.
REQ-043 During a sweep, push 4 updates -> the 5th offer sees upd_ready=0 and err_drop=1; after the sweep, the 4 entries drain on 4 consecutive cycles.
REQ-044 With 3 entries queued, pulse flush_req -> the queued entries are never written, the sweep restarts at index 0, and busy=1 for 1024 cycles.
REQ-045 Assert rst at sweep index 500 for 1 cycle -> wr_index returns to 0 asynchronously and the sweep completes 1024 cycles after release.

Source files
------------

// File: rtl/bp_table_update_ctrl.sv
// Branch-predictor table update controller.
// Sweeps the whole table to INIT_VAL after reset or a flush, and otherwise
// drains a small FIFO of resolved-branch updates into the table write port.
// Queued updates are forwarded to the predict stage so a lookup never sees
// stale table data for an entry that is still waiting to be written.
module bp_table_update_ctrl #(
    parameter int                IDX_W    = 10,
    parameter int                DATA_W   = 2,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_index,
    input  logic [DATA_W-1:0] upd_data,
    output logic              upd_ready,
    input  logic              flush_req,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_index,
    output logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              busy,
    output logic              err_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [IDX_W-1:0] SWEEP_LAST = '1;
    localparam logic [PTR_W:0]   DEPTH_CNT  = (PTR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [IDX_W-1:0]  sweep_cnt;

    logic [IDX_W-1:0]  idx_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  slot;

    // A full FIFO refuses new entries even when the head leaves this cycle;
    // a flush cycle refuses them too since the queue is being discarded.
    assign upd_ready = (count < DEPTH_CNT) && !flush_req;
    assign push      = upd_valid && upd_ready;
    assign busy      = (state != ST_RUN);
    assign pop       = (state == ST_RUN) && (count != '0);

    // Sweep sequencer: walk every index once, then hand the port to the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
        end else if (flush_req) begin
            state     <= ST_FLUSH;
            sweep_cnt <= '0;
        end else if (state != ST_RUN) begin
            if (sweep_cnt == SWEEP_LAST) begin
                state     <= ST_RUN;
                sweep_cnt <= '0;
            end else begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents only matter while the slot is counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wr_ptr]  <= upd_index;
            data_mem[wr_ptr] <= upd_data;
        end
    end

    // Sticky record of any update that was offered but not taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_drop <= 1'b0;
        end else if (upd_valid && !upd_ready) begin
            err_drop <= 1'b1;
        end
    end

    // Write port mux: sweep writes win, otherwise the FIFO head drains.
    always_comb begin
        wr_en    = 1'b0;
        wr_index = '0;
        wr_data  = '0;
        if (busy) begin
            wr_en    = 1'b1;
            wr_index = sweep_cnt;
            wr_data  = INIT_VAL;
        end else if (pop) begin
            wr_en    = 1'b1;
            wr_index = idx_mem[rd_ptr];
            wr_data  = data_mem[rd_ptr];
        end
    end

    // Forwarding scan from oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count) && (idx_mem[slot] == rd_index)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[slot];
            end
        end
    end

endmodule

// File: tb/tb_bp_table_update_ctrl.sv
// Self-checking bench for bp_table_update_ctrl.
// A queue-based reference model tracks the pending updates and the sweep
// position; every cycle the DUT outputs are compared against it, and the
// directed scenarios add fixed expectations on write order and sweep length.
module tb_bp_table_update_ctrl;

    localparam int               IDX_W    = 10;
    localparam int               DATA_W   = 2;
    localparam int               DEPTH    = 4;
    localparam logic [DATA_W-1:0] INIT_VAL = 2'b10;
    localparam int               TBL      = 1 << IDX_W;

    logic              clk;
    logic              rst;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_index;
    logic [DATA_W-1:0] upd_data;
    logic              upd_ready;
    logic              flush_req;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_index;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  rd_index;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              busy;
    logic              err_drop;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } upd_t;

    upd_t mq[$];
    upd_t seen_wr[$];
    bit   m_busy;
    int   m_sweep;
    bit   m_err;
    int   checks;
    int   failures;

    bp_table_update_ctrl #(
        .IDX_W   (IDX_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .INIT_VAL(INIT_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .upd_valid(upd_valid),
        .upd_index(upd_index),
        .upd_data (upd_data),
        .upd_ready(upd_ready),
        .flush_req(flush_req),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_data  (wr_data),
        .rd_index (rd_index),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .busy     (busy),
        .err_drop (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_busy  = 1'b1;
        m_sweep = 0;
        m_err   = 1'b0;
    endtask

    // Compare all outputs against the model for the current cycle's inputs.
    task automatic checkCycle();
        logic              e_ready;
        logic              e_wr_en;
        logic [IDX_W-1:0]  e_idx;
        logic [DATA_W-1:0] e_data;
        logic              e_hit;
        logic [DATA_W-1:0] e_fwd;
        e_ready = (mq.size() < DEPTH) && !flush_req;
        e_wr_en = 1'b0;
        e_idx   = '0;
        e_data  = '0;
        if (m_busy) begin
            e_wr_en = 1'b1;
            e_idx   = IDX_W'(m_sweep);
            e_data  = INIT_VAL;
        end else if (mq.size() > 0) begin
            e_wr_en = 1'b1;
            e_idx   = mq[0].idx;
            e_data  = mq[0].data;
        end
        e_hit = 1'b0;
        e_fwd = '0;
        foreach (mq[i]) begin
            if (mq[i].idx == rd_index) begin
                e_hit = 1'b1;
                e_fwd = mq[i].data;
            end
        end
        checkOutput("busy", busy, m_busy);
        checkOutput("upd_ready", upd_ready, e_ready);
        checkOutput("wr_en", wr_en, e_wr_en);
        checkOutput("wr_index", wr_index, e_idx);
        checkOutput("wr_data", wr_data, e_data);
        checkOutput("fwd_hit", fwd_hit, e_hit);
        checkOutput("fwd_data", fwd_data, e_fwd);
        checkOutput("err_drop", err_drop, m_err);
        if (!busy && wr_en) begin
            seen_wr.push_back({wr_index, wr_data});
        end
    endtask

    // Advance the model by one clock edge using the inputs held this cycle.
    task automatic modelEdge();
        bit acc;
        if (rst) begin
            modelReset();
        end else begin
            acc = upd_valid && (mq.size() < DEPTH) && !flush_req;
            if (upd_valid && !acc) m_err = 1'b1;
            if (flush_req) begin
                mq.delete();
                m_busy  = 1'b1;
                m_sweep = 0;
            end else begin
                if (m_busy) begin
                    if (m_sweep == TBL - 1) begin
                        m_busy  = 1'b0;
                        m_sweep = 0;
                    end else begin
                        m_sweep++;
                    end
                end else if (mq.size() > 0) begin
                    void'(mq.pop_front());
                end
                if (acc) mq.push_back({upd_index, upd_data});
            end
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, step the model.
    task automatic applyStimulus(input logic v, input int idx, input int data,
                                 input logic fl, input int rd);
        upd_valid = v;
        upd_index = IDX_W'(idx);
        upd_data  = DATA_W'(data);
        flush_req = fl;
        rd_index  = IDX_W'(rd);
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // Idle until the sweep ends (bounded) and return how many busy cycles ran.
    task automatic runSweep(output int n);
        n = 0;
        for (int c = 0; c < TBL + 64; c++) begin
            if (!busy) break;
            n++;
            applyStimulus(1'b0, 0, 0, 1'b0, 0);
        end
    endtask

    initial begin
        int   n;
        upd_t e;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_data  = '0;
        flush_req = 1'b0;
        rd_index  = '0;
        modelReset();
        @(posedge clk);
        #1;

        // Outputs while reset is held.
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_wr_en", wr_en, 1);
        checkOutput("rst_wr_index", wr_index, 0);
        checkOutput("rst_wr_data", wr_data, INIT_VAL);
        checkOutput("rst_upd_ready", upd_ready, 1);
        checkOutput("rst_fwd_hit", fwd_hit, 0);
        checkOutput("rst_err_drop", err_drop, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0);
        rst = 1'b0;

        // Initial sweep after release.
        runSweep(n);
        checkOutput("init_sweep_len", n, TBL);
        checkOutput("run_busy", busy, 0);
        checkOutput("run_idle_wr_en", wr_en, 0);

        // Back-to-back pushes in RUN drain in order.
        seen_wr.delete();
        applyStimulus(1'b1, 5, 3, 1'b0, 5);
        applyStimulus(1'b1, 9, 2, 1'b0, 5);
        applyStimulus(1'b1, 5, 1, 1'b0, 5);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 0, 1'b0, 5);
        checkOutput("run_wr_count", seen_wr.size(), 3);
        if (seen_wr.size() == 3) begin
            checkOutput("run_wr0", seen_wr[0], {10'd5, 2'b11});
            checkOutput("run_wr1", seen_wr[1], {10'd9, 2'b10});
            checkOutput("run_wr2", seen_wr[2], {10'd5, 2'b01});
        end

        // Fill the FIFO during a sweep, overflow it, then drain after.
        applyStimulus(1'b0, 0, 0, 1'b1, 0);
        applyStimulus(1'b1, 5, 3, 1'b0, 5);
        applyStimulus(1'b1, 9, 2, 1'b0, 5);
        applyStimulus(1'b1, 5, 1, 1'b0, 5);
        applyStimulus(1'b1, 7, 0, 1'b0, 5);
        upd_valid = 1'b1;
        upd_index = 10'd3;
        upd_data  = 2'b01;
        #1;
        checkOutput("full_upd_ready", upd_ready, 0);
        checkOutput("youngest_fwd_hit", fwd_hit, 1);
        checkOutput("youngest_fwd_data", fwd_data, 2'b01);
        applyStimulus(1'b1, 3, 1, 1'b0, 5);
        checkOutput("overflow_err_drop", err_drop, 1);
        runSweep(n);
        checkOutput("flush_sweep_rest", n, TBL - 5);
        seen_wr.delete();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, 0, 1'b0, 0);
        checkOutput("drain_count", seen_wr.size(), 4);
        if (seen_wr.size() == 4) begin
            checkOutput("drain0", seen_wr[0], {10'd5, 2'b11});
            checkOutput("drain1", seen_wr[1], {10'd9, 2'b10});
            checkOutput("drain2", seen_wr[2], {10'd5, 2'b01});
            checkOutput("drain3", seen_wr[3], {10'd7, 2'b00});
        end

        // Flush with entries queued: they are discarded and the sweep restarts.
        applyStimulus(1'b0, 0, 0, 1'b1, 0);
        applyStimulus(1'b1, 1, 1, 1'b0, 1);
        applyStimulus(1'b1, 2, 2, 1'b0, 1);
        applyStimulus(1'b1, 3, 3, 1'b0, 1);
        seen_wr.delete();
        applyStimulus(1'b0, 0, 0, 1'b1, 1);
        checkOutput("reflush_wr_index", wr_index, 0);
        runSweep(n);
        checkOutput("reflush_sweep_len", n, TBL);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1);
        checkOutput("discarded_writes", seen_wr.size(), 0);

        // Asynchronous reset in the middle of a sweep.
        applyStimulus(1'b0, 0, 0, 1'b1, 0);
        for (int i = 0; i < 500; i++) applyStimulus(1'b0, 0, 0, 1'b0, 0);
        checkOutput("mid_sweep_index", wr_index, 500);
        rst = 1'b1;
        #1;
        checkOutput("async_wr_index", wr_index, 0);
        checkOutput("async_busy", busy, 1);
        checkOutput("async_upd_ready", upd_ready, 1);
        modelReset();
        applyStimulus(1'b0, 0, 0, 1'b0, 0);
        rst = 1'b0;
        runSweep(n);
        checkOutput("post_rst_sweep_len", n, TBL);

        // Randomized traffic with occasional flushes, checked against the model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)), ($urandom_range(0, 299) == 0),
                          int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
